logic_unit_pipe: RTL and testbench

//  Parametrised, registered successor to the 1-bit AND/OR select mux. Applies one of four

---
 rtl/logic_unit_pkg.sv | 15 +
 rtl/logic_unit_core.sv | 26 ++
 rtl/logic_unit_pipe.sv | 116 +++++++++++
 tb/tb_logic_unit_pipe.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: shared types and default sizes for the registered logic unit.
// Optional feature macro used by the top: LU_STATUS_FLAGS_EN (zero/parity outputs).
package logic_unit_pkg;

    typedef enum logic [1:0] {
        LU_OR   = 2'b00,
        LU_AND  = 2'b01,
        LU_XOR  = 2'b10,
        LU_NAND = 2'b11
    } lu_op_e;

    localparam int LU_DEF_WIDTH = 8;
    localparam int LU_DEF_CNT_W = 16;

endpackage

// File: rtl/logic_unit_core.sv
// logic_unit_core: purely combinational bitwise function f(sel, a, b) over WIDTH lanes.
// Lanes are independent; OR/AND encodings match the original 1-bit select mux.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = LU_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Select one of the four bitwise functions per lane.
    always_comb begin
        y = '0;
        case (lu_op_e'(sel))
            LU_OR:   y = a | b;
            LU_AND:  y = a & b;
            LU_XOR:  y = a ^ b;
            LU_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: bitwise logic unit with a one-entry valid/ready output register,
// an accumulator that can replace operand A, and a consumed-result counter.
// Optional feature macro: LU_STATUS_FLAGS_EN adds registered zero/parity outputs.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = LU_DEF_WIDTH,
    parameter int CNT_W = LU_DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       sel,
    input  logic             acc_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [CNT_W-1:0] op_count
`ifdef LU_STATUS_FLAGS_EN
    ,
    output logic             zero,
    output logic             parity
`endif
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] f_out;
    logic             accept;
    logic             drain;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid_q && out_ready;
    assign op_a     = acc_en ? acc_q : a;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .a   (op_a),
        .b   (b),
        .sel (sel),
        .y   (f_out)
    );

    // Next-state: load on accept, clear valid on a bare drain, otherwise hold.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        acc_d       = acc_q;
        op_count_d  = op_count_q;
        if (accept) begin
            out_valid_d = 1'b1;
            result_d    = f_out;
            acc_d       = f_out;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
        if (drain) begin
            op_count_d = op_count_q + CNT_W'(1);
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            acc_q       <= '0;
            op_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            acc_q       <= acc_d;
            op_count_q  <= op_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign op_count  = op_count_q;

`ifdef LU_STATUS_FLAGS_EN
    logic zero_q, zero_d;
    logic parity_q, parity_d;

    // Status flags follow the result register's load/hold behaviour.
    always_comb begin
        zero_d   = zero_q;
        parity_d = parity_q;
        if (accept) begin
            zero_d   = (f_out == '0);
            parity_d = ^f_out;
        end
    end

    // Status flag registers, cleared by reset like the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    assign zero   = zero_q;
    assign parity = parity_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed self-checking bench for logic_unit_pipe (WIDTH=8, CNT_W=4).
// Status-flag checks are compiled only when LU_STATUS_FLAGS_EN is defined.
module tb_logic_unit_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] sel;
    logic       acc_en;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] op_count;
`ifdef LU_STATUS_FLAGS_EN
    logic       zero;
    logic       parity;
`endif

    int compared;
    int mismatched;

    logic_unit_pipe #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .op_count  (op_count)
`ifdef LU_STATUS_FLAGS_EN
        ,
        .zero      (zero),
        .parity    (parity)
`endif
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer one beat for a single edge, then return inputs to unknown with in_valid low.
    task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic [1:0] isel, input logic iacc);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        sel      = isel;
        acc_en   = iacc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 'x;
        b        = 'x;
        sel      = 'x;
        acc_en   = 1'bx;
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1;
    endtask

    // Assert reset between edges and release it on a falling edge.
    task automatic pulseReset();
        #3;
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_ready = 1'b1;
        applyStimulus(8'h0F, 8'hF0, 2'b00, 1'b0);
        idleCycle();
        out_ready = 1'b0;
        applyStimulus(8'h81, 8'h00, 2'b00, 1'b0);
        compared++;
        if (op_count !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL pre_reset_count got %0d want 1", op_count);
        end
        #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_out_valid got %b want 0", out_valid);
        end
        compared++;
        if (result !== 8'h00) begin
            mismatched++;
            $display("[TB] FAIL reset_result got %h want 00", result);
        end
        compared++;
        if (op_count !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_op_count got %0d want 0", op_count);
        end
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idleCycle();
    endtask

    task automatic test_functions();
        logic [7:0] exp_res [4];
        exp_res = '{8'hFC, 8'hC0, 8'h3C, 8'h3F};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(8'hF0, 8'hCC, 2'(i), 1'b0);
            compared++;
            if (result !== exp_res[i] || out_valid !== 1'b1) begin
                mismatched++;
                $display("[TB] FAIL func_sel%0d got %h/v%b want %h/v1", i, result, out_valid, exp_res[i]);
            end
        end
        idleCycle();
        compared++;
        if (op_count !== 4'd4) begin
            mismatched++;
            $display("[TB] FAIL func_op_count got %0d want 4", op_count);
        end
        compared++;
        if (out_valid !== 1'b0 || result !== 8'h3F) begin
            mismatched++;
            $display("[TB] FAIL drain_hold got %h/v%b want 3f/v0", result, out_valid);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        applyStimulus(8'hAA, 8'h0F, 2'b01, 1'b0);
        in_valid = 1'b1;
        a        = 8'hFF;
        b        = 8'hFF;
        sel      = 2'b00;
        acc_en   = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idleCycle();
            compared++;
            if (result !== 8'h0A || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL bp_hold_%0d got %h/v%b/r%b want 0a/v1/r0", i, result, out_valid, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        compared++;
        if (in_ready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_release_ready got %b want 1", in_ready);
        end
        applyStimulus(8'hFF, 8'hFF, 2'b00, 1'b0);
        compared++;
        if (result !== 8'hFF || out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL bp_second_beat got %h/v%b want ff/v1", result, out_valid);
        end
        applyStimulus(8'h12, 8'h34, 2'b10, 1'b0);
        compared++;
        if (result !== 8'h26 || out_valid !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL b2b_third_beat got %h/v%b want 26/v1", result, out_valid);
        end
        idleCycle();
        compared++;
        if (op_count !== 4'd7) begin
            mismatched++;
            $display("[TB] FAIL bp_op_count got %0d want 7", op_count);
        end
    endtask

    task automatic test_accumulate();
        out_ready = 1'b1;
        applyStimulus(8'h0F, 8'h30, 2'b00, 1'b0);
        compared++;
        if (result !== 8'h3F) begin
            mismatched++;
            $display("[TB] FAIL acc_first got %h want 3f", result);
        end
        applyStimulus(8'hXX, 8'h3C, 2'b10, 1'b1);
        compared++;
        if (result !== 8'h03) begin
            mismatched++;
            $display("[TB] FAIL acc_chain got %h want 03", result);
        end
        idleCycle();
        compared++;
        if (op_count !== 4'd9) begin
            mismatched++;
            $display("[TB] FAIL acc_op_count got %0d want 9", op_count);
        end
    endtask

    task automatic test_wrap_and_reset();
        out_ready = 1'b1;
        pulseReset();
        applyStimulus(8'hFF, 8'h5A, 2'b00, 1'b1);
        compared++;
        if (result !== 8'h5A) begin
            mismatched++;
            $display("[TB] FAIL post_reset_acc got %h want 5a", result);
        end
        for (int i = 1; i < 17; i++) begin
            applyStimulus(8'(i), 8'h00, 2'b00, 1'b0);
        end
        compared++;
        if (result !== 8'h10) begin
            mismatched++;
            $display("[TB] FAIL wrap_last_result got %h want 10", result);
        end
        idleCycle();
        compared++;
        if (op_count !== 4'd1) begin
            mismatched++;
            $display("[TB] FAIL wrap_op_count got %0d want 1", op_count);
        end
        out_ready = 1'b0;
        applyStimulus(8'h77, 8'h11, 2'b01, 1'b0);
        compared++;
        if (out_valid !== 1'b1 || result !== 8'h11) begin
            mismatched++;
            $display("[TB] FAIL bp_before_reset got %h/v%b want 11/v1", result, out_valid);
        end
        #3;
        rst_n = 1'b0;
        #1;
        compared++;
        if (out_valid !== 1'b0 || result !== 8'h00 || op_count !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_drop got %h/v%b/c%0d want 00/v0/c0", result, out_valid, op_count);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idleCycle();
        idleCycle();
        compared++;
        if (out_valid !== 1'b0 || op_count !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL after_reset_idle got v%b/c%0d want v0/c0", out_valid, op_count);
        end
    endtask

`ifdef LU_STATUS_FLAGS_EN
    task automatic test_status_flags();
        out_ready = 1'b1;
        applyStimulus(8'h55, 8'h55, 2'b10, 1'b0);
        compared++;
        if (result !== 8'h00 || zero !== 1'b1 || parity !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL flags_zero got %h/z%b/p%b want 00/z1/p0", result, zero, parity);
        end
        applyStimulus(8'h01, 8'h00, 2'b00, 1'b0);
        compared++;
        if (result !== 8'h01 || zero !== 1'b0 || parity !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL flags_parity got %h/z%b/p%b want 01/z0/p1", result, zero, parity);
        end
        idleCycle();
    endtask
`endif

    // Sequence the scenarios and report the totals.
    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        a          = '0;
        b          = '0;
        sel        = '0;
        acc_en     = 1'b0;
        out_ready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idleCycle();
        $display("[TB] starting directed tests");
        test_reset();
        test_functions();
        test_backpressure();
        test_accumulate();
        test_wrap_and_reset();
`ifdef LU_STATUS_FLAGS_EN
        test_status_flags();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
